tone_decoder: RTL

- Receive-side counterpart of the sine tone generator: measures the period of an incoming tone and recovers the 2-bit frequency code (0=600 Hz, 1=800 Hz, 2=1200 Hz, 3=1600 Hz).
- The input is the digital square wave from the receive board's analog comparator.
- The block synchronises and glitch-filters that input, times rising edge to rising edge, classifies each period into a band, and asserts valid after consecutive matching periods.

---
 rtl/tone_decoder.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/tone_decoder.sv
// Tone period decoder: synchronises and glitch-filters a comparator square wave, times rising edges
// and recovers the 2-bit tone code. Define TONE_DECODER_PERIOD_OUT_EN to add period_out/period_stb.

module tone_decoder #(
    parameter int unsigned FILT_LEN  = 16,
    parameter int unsigned P0        = 166667,
    parameter int unsigned P1        = 125000,
    parameter int unsigned P2        = 83333,
    parameter int unsigned P3        = 62500,
    parameter int unsigned TOL_SHIFT = 4,
    parameter int unsigned MATCH_N   = 4,
    parameter int unsigned TIMEOUT   = 262143
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic [1:0]  freq,
    output logic        valid,
    output logic        new_tone,
`ifdef TONE_DECODER_PERIOD_OUT_EN
    output logic        lost,
    output logic [17:0] period_out,
    output logic        period_stb
`else
    output logic        lost
`endif
);

    localparam int unsigned CNT_W  = 18;
    localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned MCNT_W = $clog2(MATCH_N + 1);

    localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [FCNT_W-1:0] FILT_MAX  = FCNT_W'(FILT_LEN - 1);
    localparam logic [MCNT_W-1:0] MATCH_V   = MCNT_W'(MATCH_N);

    localparam logic [CNT_W-1:0] LO0 = CNT_W'(P0 - (P0 >> TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI0 = CNT_W'(P0 + (P0 >> TOL_SHIFT));
    localparam logic [CNT_W-1:0] LO1 = CNT_W'(P1 - (P1 >> TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI1 = CNT_W'(P1 + (P1 >> TOL_SHIFT));
    localparam logic [CNT_W-1:0] LO2 = CNT_W'(P2 - (P2 >> TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI2 = CNT_W'(P2 + (P2 >> TOL_SHIFT));
    localparam logic [CNT_W-1:0] LO3 = CNT_W'(P3 - (P3 >> TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI3 = CNT_W'(P3 + (P3 >> TOL_SHIFT));

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic              sync1;
    logic              sync2;
    logic              filt;
    logic              filt_d;
    logic [FCNT_W-1:0] fcnt;
    logic [CNT_W-1:0]  cnt;
    logic              rise_c;
    logic              timeout_c;
    logic              band_hit_c;
    logic [1:0]        band_c;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [1:0]        cand;
    logic [1:0]        cand_n;
    logic [MCNT_W-1:0] mcnt;
    logic [MCNT_W-1:0] mcnt_n;
    logic [1:0]        freq_n;
    logic              valid_n;
    logic              new_tone_n;
    logic              lost_n;

    // Two-flop synchroniser followed by a level filter needing FILT_LEN agreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            fcnt   <= '0;
        end else begin
            sync1  <= tone_in;
            sync2  <= sync1;
            filt_d <= filt;
            if (sync2 != filt) begin
                if (fcnt == FILT_MAX) begin
                    filt <= ~filt;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + FCNT_W'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign rise_c    = filt & ~filt_d;
    assign timeout_c = (cnt == TIMEOUT_V);

    // Edge-to-edge period counter; restarts at 1 so its value on an edge is the full period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise_c) begin
            cnt <= CNT_W'(1);
        end else if (cnt < TIMEOUT_V) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Band classifier; a saturated count lies above every band and reads as no match
    always_comb begin
        band_hit_c = 1'b0;
        band_c     = 2'd0;
        if (cnt >= LO0 && cnt <= HI0) begin
            band_hit_c = 1'b1;
            band_c     = 2'd0;
        end
        if (cnt >= LO1 && cnt <= HI1) begin
            band_hit_c = 1'b1;
            band_c     = 2'd1;
        end
        if (cnt >= LO2 && cnt <= HI2) begin
            band_hit_c = 1'b1;
            band_c     = 2'd2;
        end
        if (cnt >= LO3 && cnt <= HI3) begin
            band_hit_c = 1'b1;
            band_c     = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cand     <= 2'd0;
            mcnt     <= '0;
            freq     <= 2'd0;
            valid    <= 1'b0;
            new_tone <= 1'b0;
            lost     <= 1'b0;
        end else begin
            state    <= state_n;
            cand     <= cand_n;
            mcnt     <= mcnt_n;
            freq     <= freq_n;
            valid    <= valid_n;
            new_tone <= new_tone_n;
            lost     <= lost_n;
        end
    end

    // Lock tracking; an edge always takes priority over a simultaneous timeout
    always_comb begin
        state_n    = state;
        cand_n     = cand;
        mcnt_n     = mcnt;
        freq_n     = freq;
        valid_n    = valid;
        new_tone_n = 1'b0;
        lost_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise_c) begin
                    state_n = S_MEASURE;
                    mcnt_n  = '0;
                end
            end
            S_MEASURE: begin
                if (rise_c) begin
                    if (!band_hit_c) begin
                        mcnt_n = '0;
                    end else if (band_c == cand) begin
                        mcnt_n = mcnt + MCNT_W'(1);
                    end else begin
                        cand_n = band_c;
                        mcnt_n = MCNT_W'(1);
                    end
                    if (mcnt_n == MATCH_V) begin
                        state_n    = S_LOCKED;
                        freq_n     = cand_n;
                        valid_n    = 1'b1;
                        new_tone_n = 1'b1;
                        mcnt_n     = '0;
                    end
                end else if (timeout_c) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                    mcnt_n  = '0;
                end
            end
            S_LOCKED: begin
                if (rise_c) begin
                    if (!band_hit_c) begin
                        state_n = S_MEASURE;
                        mcnt_n  = '0;
                        valid_n = 1'b0;
                    end else if (band_c != freq) begin
                        state_n = S_MEASURE;
                        cand_n  = band_c;
                        mcnt_n  = MCNT_W'(1);
                        valid_n = 1'b0;
                    end
                end else if (timeout_c) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                    lost_n  = 1'b1;
                    mcnt_n  = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
                mcnt_n  = '0;
            end
        endcase
    end

`ifdef TONE_DECODER_PERIOD_OUT_EN
    // Every classified edge (any state but IDLE) publishes the measured period
    always_ff @(posedge clk) begin
        if (rst) begin
            period_out <= '0;
            period_stb <= 1'b0;
        end else begin
            period_stb <= rise_c && (state != S_IDLE);
            if (rise_c && (state != S_IDLE)) begin
                period_out <= cnt;
            end
        end
    end
`endif

endmodule
